ctl_shot: RTL and testbench
===========================

// Module: ctl_shot
// PURPOSE
//  Shot resolver: the consumer of the duck position from the duck controller. It takes a trigger and
//  the cursor position, then runs a light-gun style flash sequence: one black frame, then the target frame.
//  It resolves hit or miss against the duck box and returns hit/miss pulses and shots left to game control.
//  It drives flash overrides into the draw pipeline. Screen space is 1024x768, 10-bit coordinates.
// PARAMETERS
//  DUCK_W           64  duck hit-box width, px
//  DUCK_H           64  duck hit-box height, px
//  SHOTS            3   shots per round, reloaded on game_start (1..3)
//  FLASH_FRAMES     1   frames spent in BLACK and frames spent in TARGET
//  COOLDOWN_FRAMES  15  frames after result before next shot accepted
// PORTS
//  clk            in   1   system clock
//  rst            in   1   asynchronous, active-high reset
//  new_frame      in   1   1-cycle pulse per video frame
//  game_start     in   1   reload shots / abort sequence
//  trigger        in   1   fire button level, already synchronised to clk
//  cursor_x       in   10  crosshair x
//  cursor_y       in   10  crosshair y
//  duck_x         in   10  duck top-left x (from duck controller)
//  duck_y         in   10  duck top-left y
//  duck_show      in   1   duck currently on screen
//  shot_hit       out  1   1-cycle pulse: shot resolved as hit
//  shot_miss      out  1   1-cycle pulse: shot resolved as miss
//  shots_left     out  2   remaining shots
//  flash_black    out  1   draw pipeline: blank whole screen
//  flash_target   out  1   draw pipeline: blank screen except duck box (white)
//  busy           out  1   sequence in progress (state != IDLE)
// BEHAVIOUR
//  Reset: state IDLE; shots_left=SHOTS; all other outputs 0; edge register 0; latched cursor 0.
//  Trigger edge: fire = trigger & ~trigger_q. Holding trigger yields exactly one fire.
//  States: IDLE, BLACK, TARGET, RESULT, COOLDOWN. All outputs are registered.
//   IDLE: fire & shots_left!=0 & ~game_start -> BLACK.
//     Same edge: latch cursor_x/y; shots_left -= 1.
//     fire with shots_left==0: ignored, no pulse.
//   BLACK: flash_black=1. Count new_frame pulses; after FLASH_FRAMES pulses -> TARGET.
//     A new_frame in the entry cycle is not counted.
//   TARGET: flash_target=1. On the FLASH_FRAMES-th new_frame, sample hit and -> RESULT.
//     hit = duck_show & lx>=duck_x & lx<duck_x+DUCK_W & ly>=duck_y & ly<duck_y+DUCK_H.
//     lx/ly are the latched cursor; duck position is the live value in that cycle.
//   RESULT: exactly one cycle; shot_hit=hit, shot_miss=~hit -> COOLDOWN.
//   COOLDOWN: after COOLDOWN_FRAMES new_frame pulses -> IDLE.
//  Arithmetic: box sums are computed at 11 bits, zero-extended, so duck_x near 1023 does not wrap.
//    A cursor exactly on duck_x+DUCK_W or duck_y+DUCK_H is a miss.
//  Latency:
//    fire in cycle T -> busy/flash_black asserted at T+1.
//    shot_hit/miss one cycle after the resolving new_frame.
//  fire while busy: ignored; it is not queued and shots are not consumed.
//  game_start (any state, highest priority):
//    next state IDLE; shots_left=SHOTS; frame counter cleared; no hit/miss pulse; flashes drop next cycle.
//    fire in the same cycle as game_start is ignored.
//  new_frame coincident with state entry: not counted.
//  Frame counter is 5 bits and is cleared on every state change.
//  Async rst mid-sequence: immediate return to reset values.
// STRUCTURE
//  duck_pkg: SCREEN_W=1024, SCREEN_H=768, DUCK_W/DUCK_H defaults, shot_state_t enum (3 bits).
//  Sub-module edge_rise: 1-bit rising-edge detector (clk, rst, in, pulse).
//  Reused later for mouse/button inputs.
//  Body: state register, frame counter, latched cursor, shots counter, registered outputs;
//  next-state and next-output logic in separate always_comb blocks with defaults assigned first.
// TESTING
//  1 Hit: duck (100,200) show=1, cursor (130,230), fire, 2 frames
//    -> black 1 frame, target 1 frame, shot_hit 1 cycle, shots_left 3->2.
//  2 Miss and edge: cursor (164,230), duck (100,200) -> shot_miss (x=duck_x+64 excluded);
//    cursor (163,264) -> shot_miss (y edge excluded).
//  3 Wrap: duck_x=1000, cursor_x=1020, y inside -> shot_hit; no 10-bit wraparound false miss.
//  4 Exhaust and cooldown:
//    3 fires each after cooldown -> shots_left 0, 4th fire no busy/pulse;
//    fire during COOLDOWN frame 5 -> ignored.
//  5 Held trigger: trigger high for 40 frames -> exactly one sequence, shots_left decremented once.
//  6 Abort: game_start asserted in TARGET
//    -> IDLE next cycle, no pulse, shots_left=3, flash_target low;
//    async rst in BLACK -> all outputs reset values immediately.

Source files
------------

// File: rtl/duck_pkg.sv
// -----------------------------------------------------------------------------
// duck_pkg
//   Shared definitions for the duck-hunt game blocks: screen geometry, default
//   duck hit-box size, the shot resolver state encoding and a span test used
//   for hit detection.
// -----------------------------------------------------------------------------
package duck_pkg;

  localparam int unsigned COORD_W    = 10;
  localparam int unsigned SCREEN_W   = 1024;
  localparam int unsigned SCREEN_H   = 768;
  localparam int unsigned DUCK_W_DEF = 64;
  localparam int unsigned DUCK_H_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_BLACK    = 3'd1,
    ST_TARGET   = 3'd2,
    ST_RESULT   = 3'd3,
    ST_COOLDOWN = 3'd4
  } shot_state_t;

  // True when base <= pos < base + size. The upper limit is formed at
  // COORD_W+1 bits so a box that starts near the right/bottom edge of the
  // coordinate range does not wrap to a small value.
  function automatic logic in_span(input logic [COORD_W-1:0] pos,
                                   input logic [COORD_W-1:0] base,
                                   input logic [COORD_W:0]   size);
    logic [COORD_W:0] limit;
    limit = {1'b0, base} + size;
    return (pos >= base) && ({1'b0, pos} < limit);
  endfunction

endpackage

// File: rtl/edge_rise.sv
// -----------------------------------------------------------------------------
// edge_rise
//   1-bit rising-edge detector. The pulse is combinational from the current
//   input and the registered previous value, so a rise is visible in the same
//   cycle the input goes high. Input must already be synchronous to clk.
// Ports
//   clk    in  system clock
//   rst    in  asynchronous, active-high reset (clears the history register)
//   in     in  level input
//   pulse  out high for the first cycle in which `in` is high after being low
// -----------------------------------------------------------------------------
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);

  logic in_q;

  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_q <= 1'b0;
    else     in_q <= in;
  end

  assign pulse = in & ~in_q;

endmodule

// File: rtl/ctl_shot.sv
// -----------------------------------------------------------------------------
// ctl_shot
//   Light-gun style shot resolver. A trigger press latches the cursor, spends
//   FLASH_FRAMES frames with the whole screen black, then FLASH_FRAMES frames
//   with only the duck box lit, and on the last target frame decides hit or
//   miss against the live duck box. After the one-cycle result it waits
//   COOLDOWN_FRAMES frames before another shot is accepted.
//   SHOTS must be 1..3; FLASH_FRAMES and COOLDOWN_FRAMES must be 1..32.
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   new_frame       1-cycle pulse per video frame
//   game_start      reload shots and abort any sequence (highest priority)
//   trigger         fire button level, synchronous to clk
//   cursor_x/y      crosshair position
//   duck_x/y        duck top-left corner, duck_show = duck visible
//   shot_hit/miss   1-cycle result pulses
//   shots_left      remaining shots this round
//   flash_black     draw pipeline: blank whole screen
//   flash_target    draw pipeline: blank all but the duck box
//   busy            a shot sequence is in progress
// -----------------------------------------------------------------------------
module ctl_shot
  import duck_pkg::*;
#(
  parameter int unsigned DUCK_W          = DUCK_W_DEF,
  parameter int unsigned DUCK_H          = DUCK_H_DEF,
  parameter int unsigned SHOTS           = 3,
  parameter int unsigned FLASH_FRAMES    = 1,
  parameter int unsigned COOLDOWN_FRAMES = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               new_frame,
  input  logic               game_start,
  input  logic               trigger,
  input  logic [COORD_W-1:0] cursor_x,
  input  logic [COORD_W-1:0] cursor_y,
  input  logic [COORD_W-1:0] duck_x,
  input  logic [COORD_W-1:0] duck_y,
  input  logic               duck_show,
  output logic               shot_hit,
  output logic               shot_miss,
  output logic [1:0]         shots_left,
  output logic               flash_black,
  output logic               flash_target,
  output logic               busy
);

  localparam logic [COORD_W:0] BOX_W      = (COORD_W+1)'(DUCK_W);
  localparam logic [COORD_W:0] BOX_H      = (COORD_W+1)'(DUCK_H);
  localparam logic [1:0]       SHOTS_INIT = 2'(SHOTS);
  // Counter value on which the final counted frame of a state arrives.
  localparam logic [4:0]       FLASH_LAST = 5'(FLASH_FRAMES - 1);
  localparam logic [4:0]       COOL_LAST  = 5'(COOLDOWN_FRAMES - 1);

  // ---------------------------------------------------------------------------
  // Trigger edge
  // ---------------------------------------------------------------------------
  logic fire;

  edge_rise u_trigger_edge (
    .clk   (clk),
    .rst   (rst),
    .in    (trigger),
    .pulse (fire)
  );

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  shot_state_t        state,      state_n;
  logic [4:0]         frame_cnt,  frame_cnt_n;
  logic [COORD_W-1:0] lx,         lx_n;
  logic [COORD_W-1:0] ly,         ly_n;
  logic [1:0]         shots_n;

  logic shot_hit_n, shot_miss_n, flash_black_n, flash_target_n, busy_n;
  logic hit_now;

  // Hit test uses the cursor latched at fire time and the duck as it is now.
  assign hit_now = duck_show
                 && in_span(lx, duck_x, BOX_W)
                 && in_span(ly, duck_y, BOX_H);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    state_n     = state;
    frame_cnt_n = frame_cnt;
    shots_n     = shots_left;
    lx_n        = lx;
    ly_n        = ly;

    case (state)
      ST_IDLE: begin
        // Presses with no shots left, or in the same cycle as a restart, are
        // dropped without any feedback.
        if (fire && (shots_left != 2'd0) && !game_start) begin
          state_n = ST_BLACK;
          lx_n    = cursor_x;
          ly_n    = cursor_y;
          shots_n = shots_left - 2'd1;
        end
      end

      ST_BLACK: begin
        if (new_frame) begin
          if (frame_cnt == FLASH_LAST) state_n     = ST_TARGET;
          else                         frame_cnt_n = frame_cnt + 5'd1;
        end
      end

      ST_TARGET: begin
        if (new_frame) begin
          if (frame_cnt == FLASH_LAST) state_n     = ST_RESULT;
          else                         frame_cnt_n = frame_cnt + 5'd1;
        end
      end

      ST_RESULT: state_n = ST_COOLDOWN;

      ST_COOLDOWN: begin
        if (new_frame) begin
          if (frame_cnt == COOL_LAST) state_n     = ST_IDLE;
          else                        frame_cnt_n = frame_cnt + 5'd1;
        end
      end

      default: state_n = ST_IDLE;
    endcase

    // Each state counts its own frames from zero; a frame pulse arriving on
    // the transition edge belongs to neither state.
    if (state_n != state) frame_cnt_n = '0;

    if (game_start) begin
      state_n     = ST_IDLE;
      frame_cnt_n = '0;
      shots_n     = SHOTS_INIT;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-output logic: outputs are registered copies of what the next state
  // implies, so they line up exactly with the state register.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_n         = (state_n != ST_IDLE);
    flash_black_n  = (state_n == ST_BLACK);
    flash_target_n = (state_n == ST_TARGET);
    // RESULT is only reachable from TARGET on the resolving frame, so the
    // hit test is sampled in exactly that cycle.
    shot_hit_n     = (state_n == ST_RESULT) &&  hit_now;
    shot_miss_n    = (state_n == ST_RESULT) && !hit_now;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: reset is asynchronous; it takes effect immediately, without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      frame_cnt    <= '0;
      lx           <= '0;
      ly           <= '0;
      shots_left   <= SHOTS_INIT;
      shot_hit     <= 1'b0;
      shot_miss    <= 1'b0;
      flash_black  <= 1'b0;
      flash_target <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      frame_cnt    <= frame_cnt_n;
      lx           <= lx_n;
      ly           <= ly_n;
      shots_left   <= shots_n;
      shot_hit     <= shot_hit_n;
      shot_miss    <= shot_miss_n;
      flash_black  <= flash_black_n;
      flash_target <= flash_target_n;
      busy         <= busy_n;
    end
  end

endmodule

// File: tb/tb_ctl_shot.sv
// -----------------------------------------------------------------------------
// tb_ctl_shot
//   Self-checking bench for ctl_shot. The reference model tracks a shot as a
//   number of remaining frames (black, target, cooldown) and shots in hand;
//   each accepted shot pushes its expected result and, once resolved, the
//   cycle its pulse is due. A separate monitor pops on every hit/miss pulse.
// -----------------------------------------------------------------------------
module tb_ctl_shot;

  localparam int SHOTS = 3;
  localparam int FLASH = 1;
  localparam int COOL  = 15;
  localparam int SEQ   = 2 * FLASH + COOL;
  localparam int FP    = 20;              // clock cycles per video frame
  localparam int DW    = 64;
  localparam int DH    = 64;

  logic       clk, rst, new_frame, game_start, trigger, duck_show;
  logic [9:0] cursor_x, cursor_y, duck_x, duck_y;
  logic       shot_hit, shot_miss, flash_black, flash_target, busy;
  logic [1:0] shots_left;

  ctl_shot #(
    .DUCK_W(DW), .DUCK_H(DH), .SHOTS(SHOTS),
    .FLASH_FRAMES(FLASH), .COOLDOWN_FRAMES(COOL)
  ) dut (
    .clk(clk), .rst(rst), .new_frame(new_frame), .game_start(game_start),
    .trigger(trigger), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .duck_x(duck_x), .duck_y(duck_y), .duck_show(duck_show),
    .shot_hit(shot_hit), .shot_miss(shot_miss), .shots_left(shots_left),
    .flash_black(flash_black), .flash_target(flash_target), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit hit;
    int due;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks, n_fail;
  int   cyc;
  int   m_shots, m_left;
  bit   m_pending, trig_prev;
  logic gs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit ref_hit(input int cx, input int cy, input int dx, input int dy,
                                 input bit show);
    return show && cx >= dx && cx < dx + DW && cy >= dy && cy < dy + DH;
  endfunction

  function automatic int clamp(input int v, input int hi);
    if (v < 0)  return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  // One clock cycle: drive inputs, advance the model, check after the edge.
  task automatic cycle(input bit trig);
    bit   nf, fire;
    exp_t e;
    nf         = (cyc % FP) == 0;
    new_frame  = nf;
    trigger    = trig;
    game_start = gs;
    fire       = trig && !trig_prev;
    if (gs) begin
      if (m_pending) begin
        exp_q.delete(exp_q.size() - 1);
        m_pending = 1'b0;
      end
      m_shots = SHOTS;
      m_left  = 0;
    end else if (m_left != 0) begin
      if (nf) begin
        m_left--;
        if (m_left == COOL) begin
          exp_q[exp_q.size() - 1].due = cyc + 1;
          m_pending = 1'b0;
        end
      end
    end else if (fire && m_shots != 0) begin
      m_shots--;
      m_left = SEQ;
      e.hit  = ref_hit(int'(cursor_x), int'(cursor_y), int'(duck_x), int'(duck_y), duck_show);
      e.due  = -1;
      exp_q.push_back(e);
      m_pending = 1'b1;
    end
    trig_prev = trig;
    @(posedge clk);
    #1;
    cyc++;
    check("busy",         busy,         m_left != 0);
    check("flash_black",  flash_black,  m_left > FLASH + COOL);
    check("flash_target", flash_target, m_left > COOL && m_left <= FLASH + COOL);
    check("shots_left",   shots_left,   m_shots);
  endtask

  task automatic run(input int n, input bit trig);
    repeat (n) cycle(trig);
  endtask

  // Keep trigger rises well away from frame pulses.
  task automatic to_safe();
    while ((cyc % FP) < 3 || (cyc % FP) > FP - 3) cycle(1'b0);
  endtask

  task automatic shoot(input int cx, input int cy);
    cursor_x = 10'(cx);
    cursor_y = 10'(cy);
    to_safe();
    cycle(1'b1);
    run(3, 1'b1);
    // Moving the crosshair after the press must not change the outcome.
    cursor_x = 10'($urandom_range(0, 1023));
    cursor_y = 10'($urandom_range(0, 767));
    cycle(1'b0);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (m_left != 0 && guard < 4 * SEQ * FP) begin
      cycle(1'b0);
      guard++;
    end
    run(2, 1'b0);
  endtask

  task automatic restart();
    to_safe();
    gs = 1'b1;
    cycle(1'b0);
    gs = 1'b0;
    cycle(1'b0);
  endtask

  task automatic set_duck(input int dx, input int dy, input bit show);
    duck_x    = 10'(dx);
    duck_y    = 10'(dy);
    duck_show = show;
  endtask

  // Result monitor, sampling mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (shot_hit || shot_miss)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, shot_hit, shot_miss}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("shot_hit",    shot_hit,  e.hit);
        check("shot_miss",   shot_miss, !e.hit);
        check("pulse_cycle", cyc,       e.due);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    m_shots = SHOTS; m_left = 0; m_pending = 1'b0; trig_prev = 1'b0;
    gs = 1'b0;
    rst = 1'b1; new_frame = 1'b0; game_start = 1'b0; trigger = 1'b0;
    cursor_x = '0; cursor_y = '0;
    set_duck(100, 200, 1'b1);

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_shots_left",   shots_left,   SHOTS);
    check("rst_busy",         busy,         0);
    check("rst_flash_black",  flash_black,  0);
    check("rst_flash_target", flash_target, 0);
    check("rst_hit_miss",     {shot_hit, shot_miss}, 0);
    rst = 1'b0;

    // Hit, then misses exactly on the right and bottom box edges
    shoot(130, 230); wait_idle();
    shoot(164, 230); wait_idle();
    shoot(163, 264); wait_idle();
    // Out of shots: press ignored
    shoot(130, 230); run(3 * FP, 1'b0);
    // Press in the same cycle as a restart is ignored
    to_safe();
    gs = 1'b1; cycle(1'b1); gs = 1'b0; run(FP, 1'b0);

    // Box near the right edge of coordinate space
    set_duck(1000, 300, 1'b1);
    shoot(1020, 310); wait_idle();
    shoot(1023, 363); wait_idle();
    shoot(999, 310);  wait_idle();
    restart();

    // Press during cooldown frame 5 is ignored and consumes nothing
    set_duck(100, 200, 1'b1);
    shoot(120, 220);
    while (m_left > COOL - 5) cycle(1'b0);
    shoot(120, 220);
    wait_idle();
    shoot(90, 220);  wait_idle();
    shoot(120, 199); wait_idle();
    shoot(120, 220); run(3 * FP, 1'b0);
    restart();

    // Trigger held for 40 frames: one shot only
    cursor_x = 10'd110; cursor_y = 10'd210;
    to_safe();
    run(40 * FP, 1'b1);
    cycle(1'b0);
    wait_idle();
    restart();

    // Restart while the target frame is shown
    shoot(130, 230);
    while (m_left > FLASH + COOL) cycle(1'b0);
    run(3, 1'b0);
    gs = 1'b1; cycle(1'b0); gs = 1'b0;
    run(3 * FP, 1'b0);

    // Asynchronous reset during the black frame
    shoot(130, 230);
    rst = 1'b1;
    #2;
    check("arst_busy",         busy,         0);
    check("arst_flash_black",  flash_black,  0);
    check("arst_flash_target", flash_target, 0);
    check("arst_shots_left",   shots_left,   SHOTS);
    check("arst_hit_miss",     {shot_hit, shot_miss}, 0);
    if (m_pending) begin
      exp_q.delete(exp_q.size() - 1);
      m_pending = 1'b0;
    end
    m_shots = SHOTS; m_left = 0; trig_prev = 1'b0;
    trigger = 1'b0; new_frame = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    run(FP, 1'b0);

    // Randomized shots around random duck positions
    for (int i = 0; i < 30; i++) begin
      int dx, dy;
      if (m_shots == 0 || $urandom_range(0, 7) == 0) restart();
      dx = $urandom_range(0, 1023);
      dy = $urandom_range(0, 767);
      set_duck(dx, dy, $urandom_range(0, 5) != 0);
      shoot(clamp(dx + $urandom_range(0, 84) - 10, 1023),
            clamp(dy + $urandom_range(0, 84) - 10, 1023));
      wait_idle();
    end

    run(FP, 1'b0);
    check("results_outstanding", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
